// File: rtl/rxshift_if.sv
// rxshift_if: receive byte handshake between the deserializer and the read side
interface rxshift_if #(parameter int DATA_BITS = 8);
  logic [DATA_BITS-1:0] o_Rx_Data;
  logic                 o_Rx_Valid;
  logic                 o_Frame_Err;
  logic                 o_Overrun;
  logic                 i_Ack;
  modport master (output o_Rx_Data, o_Rx_Valid, o_Frame_Err, o_Overrun, input i_Ack);
  modport slave  (input o_Rx_Data, o_Rx_Valid, o_Frame_Err, o_Overrun, output i_Ack);
endinterface

// File: rtl/rxshift.sv
// rxshift: oversampling UART receiver with mid-bit sampling, framing/overrun flags and ack handshake
module rxshift #(
  parameter int DATA_BITS = 8,
  parameter int BAUD_W    = 8
) (
  input  logic              i_Pclk,
  input  logic              i_Preset,
  input  logic [BAUD_W-1:0] i_Baud,
  input  logic              i_Rx_Serial,
  output logic              o_Busy,
  rxshift_if.master         bus
);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] STOP  = 3'd3;
  localparam logic [2:0] BREAK = 3'd4;
  logic [1:0]           sync_q, sync_d;
  logic [2:0]           state_q, state_d;
  logic [BAUD_W-1:0]    count_q, count_d, b, h;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d, data_q, data_d;
  logic                 valid_q, valid_d, ferr_q, ferr_d, ovr_q, ovr_d;
  logic                 rx_s, hit_h, hit_b, load, take;
  always_comb begin
    b       = (i_Baud < BAUD_W'(2)) ? BAUD_W'(2) : i_Baud;
    h       = b >> 1;
    rx_s    = sync_q[1];
    sync_d  = {sync_q[0], i_Rx_Serial};
    // >= rather than == keeps the FSM moving if i_Baud shrinks mid-frame
    hit_h   = count_q >= h - BAUD_W'(1);
    hit_b   = count_q >= b - BAUD_W'(1);
    state_d = state_q;
    count_d = count_q + BAUD_W'(1);
    idx_d   = idx_q;
    shift_d = shift_q;
    case (state_q)
      IDLE: begin
        count_d = '0;
        idx_d   = '0;
        state_d = rx_s ? IDLE : START;
      end
      START: if (hit_h) begin
        count_d = '0;
        state_d = rx_s ? IDLE : DATA;
      end
      DATA: if (hit_b) begin
        count_d         = '0;
        shift_d[idx_q]  = rx_s;
        idx_d           = idx_q + IW'(1);
        state_d         = (idx_q == IW'(DATA_BITS - 1)) ? STOP : DATA;
      end
      STOP: if (hit_b) begin
        count_d = '0;
        state_d = rx_s ? IDLE : BREAK;
      end
      BREAK: begin
        count_d = '0;
        state_d = rx_s ? IDLE : BREAK;
      end
      default: begin
        count_d = '0;
        state_d = IDLE;
      end
    endcase
    load    = (state_q == STOP) && hit_b;
    take    = load && (!valid_q || bus.i_Ack);
    data_d  = take ? shift_q : data_q;
    ferr_d  = take ? ~rx_s : ferr_q;
    valid_d = take || (valid_q && !bus.i_Ack);
    ovr_d   = (load && !take) ? 1'b1 : (bus.i_Ack && valid_q) ? 1'b0 : ovr_q;
  end
  always_ff @(posedge i_Pclk or posedge i_Preset) begin
    if (i_Preset) begin
      sync_q  <= '1;
      state_q <= IDLE;
      count_q <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end
  assign o_Busy          = state_q != IDLE;
  assign bus.o_Rx_Data   = data_q;
  assign bus.o_Rx_Valid  = valid_q;
  assign bus.o_Frame_Err = ferr_q;
  assign bus.o_Overrun   = ovr_q;
endmodule

// File: tb/tb_rxshift.sv
// tb_rxshift: directed frames against hand-computed bytes, flags and latency
module tb_rxshift;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] baud = 8'd16;
  logic       rx = 1'b1;
  logic       busy;
  int         cyc = 0, start_cyc = 0, rise_cyc = -1, n_chk = 0, n_pass = 0, lat;
  logic       vprev = 1'b0;
  rxshift_if #(.DATA_BITS(8)) bus();
  rxshift dut (.i_Pclk(clk), .i_Preset(rst), .i_Baud(baud), .i_Rx_Serial(rx), .o_Busy(busy), .bus(bus.master));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (bus.o_Rx_Valid && !vprev) rise_cyc <= cyc;
    vprev <= bus.o_Rx_Valid;
  end
  task check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task ack_pulse;
    bus.i_Ack = 1'b1;
    @(posedge clk);
    #1 bus.i_Ack = 1'b0;
  endtask
  // one pin change per clock; ack_at/limit index that same per-clock step
  task send(input logic [7:0] d, input logic stop, input int b, input int ack_at, input int limit);
    logic [9:0] f;
    f = {stop, d, 1'b0};
    start_cyc = cyc;
    for (int j = 0; j < 10 * b && j != limit; j++) begin
      rx = f[j / b];
      bus.i_Ack = (j == ack_at);
      @(posedge clk);
      #1;
    end
    bus.i_Ack = 1'b0;
  endtask
  initial begin
    bus.i_Ack = 1'b0;
    idle(3);
    check("rst_data", bus.o_Rx_Data, 0);
    check("rst_valid", bus.o_Rx_Valid, 0);
    check("rst_ferr", bus.o_Frame_Err, 0);
    check("rst_ovr", bus.o_Overrun, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    idle(2);
    rx = 1'b0;
    idle(4);
    rx = 1'b1;
    idle(20);
    check("glitch_valid", bus.o_Rx_Valid, 0);
    check("glitch_ferr", bus.o_Frame_Err, 0);
    check("glitch_ovr", bus.o_Overrun, 0);
    check("glitch_busy", busy, 0);
    send(8'hA5, 1'b1, 16, -1, -1);
    lat = rise_cyc - start_cyc;
    check("a5_data", bus.o_Rx_Data, 8'hA5);
    check("a5_valid", bus.o_Rx_Valid, 1);
    check("a5_ferr", bus.o_Frame_Err, 0);
    check("a5_ovr", bus.o_Overrun, 0);
    check("a5_latency", lat, 155);
    idle(4);
    ack_pulse;
    check("ack_valid", bus.o_Rx_Valid, 0);
    check("ack_hold", bus.o_Rx_Data, 8'hA5);
    send(8'h3C, 1'b0, 16, -1, -1);
    idle(20);
    check("3c_data", bus.o_Rx_Data, 8'h3C);
    check("3c_ferr", bus.o_Frame_Err, 1);
    check("3c_valid", bus.o_Rx_Valid, 1);
    check("break_busy", busy, 1);
    rx = 1'b1;
    idle(4);
    check("break_exit", busy, 0);
    ack_pulse;
    send(8'h11, 1'b1, 16, -1, -1);
    idle(3);
    send(8'h22, 1'b1, 16, -1, -1);
    idle(3);
    check("ovr_data", bus.o_Rx_Data, 8'h11);
    check("ovr_flag", bus.o_Overrun, 1);
    check("ovr_valid", bus.o_Rx_Valid, 1);
    check("ovr_ferr", bus.o_Frame_Err, 0);
    ack_pulse;
    check("ovr_ack_valid", bus.o_Rx_Valid, 0);
    check("ovr_ack_flag", bus.o_Overrun, 0);
    send(8'h11, 1'b1, 16, -1, -1);
    idle(3);
    send(8'h22, 1'b1, 16, 154, -1);
    idle(2);
    check("same_edge_data", bus.o_Rx_Data, 8'h22);
    check("same_edge_valid", bus.o_Rx_Valid, 1);
    check("same_edge_ovr", bus.o_Overrun, 0);
    send(8'h08, 1'b1, 16, -1, 72);
    check("mid_busy", busy, 1);
    rst = 1'b1;
    #1;
    check("arst_data", bus.o_Rx_Data, 0);
    check("arst_valid", bus.o_Rx_Valid, 0);
    check("arst_busy", busy, 0);
    rx = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    idle(3);
    send(8'h5A, 1'b1, 16, -1, -1);
    idle(2);
    check("5a_data", bus.o_Rx_Data, 8'h5A);
    check("5a_valid", bus.o_Rx_Valid, 1);
    check("5a_ferr", bus.o_Frame_Err, 0);
    ack_pulse;
    baud = 8'd1;
    idle(2);
    send(8'hF0, 1'b1, 2, -1, -1);
    idle(3);
    check("b1_data", bus.o_Rx_Data, 8'hF0);
    check("b1_valid", bus.o_Rx_Valid, 1);
    ack_pulse;
    baud = 8'd0;
    idle(2);
    send(8'h0F, 1'b1, 2, -1, -1);
    idle(3);
    check("b0_data", bus.o_Rx_Data, 8'h0F);
    check("b0_valid", bus.o_Rx_Valid, 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
